// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz timing constants and the 12-bit colour layout shared
// by the raster scan controller and its sync generator.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE      = 640;
  localparam int DEF_H_FRONT        = 16;
  localparam int DEF_H_SYNC         = 96;
  localparam int DEF_H_BACK         = 48;
  localparam int DEF_V_VISIBLE      = 480;
  localparam int DEF_V_FRONT        = 10;
  localparam int DEF_V_SYNC         = 2;
  localparam int DEF_V_BACK         = 33;
  localparam int DEF_CLK_DIV        = 4;
  localparam int DEF_LOOKUP_LATENCY = 2;

  localparam int DEF_H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } color_t;

endpackage

// File: rtl/vga_sync_gen.sv
// Pixel-rate divider and x/y raster counters; exposes the next counter values
// with their active/sync levels so the top can register them on the strobe.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       pixStrobe,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] xNext,
  output logic [9:0] yNext,
  output logic       activeNext,
  output logic       hSyncNext,
  output logic       vSyncNext,
  output logic       frameStart
);

  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] divCount;
  logic             xWrap;
  logic             yWrap;

  assign pixStrobe = (divCount == DIV_W'(CLK_DIV - 1));
  assign xWrap     = (x == 10'(H_TOTAL - 1));
  assign yWrap     = (y == 10'(V_TOTAL - 1));

  always_comb begin
    xNext = x;
    yNext = y;
    if (pixStrobe) begin
      xNext = xWrap ? '0 : x + 10'd1;
      if (xWrap) begin
        yNext = yWrap ? '0 : y + 10'd1;
      end
    end
  end

  assign activeNext = (xNext < 10'(H_VISIBLE)) && (yNext < 10'(V_VISIBLE));
  assign hSyncNext  = !((xNext >= 10'(H_SYNC_START)) && (xNext < 10'(H_SYNC_END)));
  assign vSyncNext  = !((yNext >= 10'(V_SYNC_START)) && (yNext < 10'(V_SYNC_END)));

  // frameStart is registered so it lands in the clk where both counters read 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      divCount   <= '0;
      x          <= '0;
      y          <= '0;
      frameStart <= 1'b0;
    end else begin
      divCount   <= pixStrobe ? '0 : divCount + DIV_W'(1);
      x          <= xNext;
      y          <= yNext;
      frameStart <= pixStrobe && xWrap && yWrap;
    end
  end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster scan controller: issues image addresses and drives colour and sync
// pins one pixel behind the counters, matching the lookup's return time.
module vga_scan_controller
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE      = DEF_H_VISIBLE,
  parameter int H_FRONT        = DEF_H_FRONT,
  parameter int H_SYNC         = DEF_H_SYNC,
  parameter int H_BACK         = DEF_H_BACK,
  parameter int V_VISIBLE      = DEF_V_VISIBLE,
  parameter int V_FRONT        = DEF_V_FRONT,
  parameter int V_SYNC         = DEF_V_SYNC,
  parameter int V_BACK         = DEF_V_BACK,
  parameter int CLK_DIV        = DEF_CLK_DIV,
  parameter int LOOKUP_LATENCY = DEF_LOOKUP_LATENCY
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [11:0] colorData,
  output logic [31:0] imgAddress,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        vblank,
  output logic        frameStart
);

  // Colour must settle before the next strobe samples it.
  if (CLK_DIV <= LOOKUP_LATENCY) begin : gLatencyCheck
    $fatal(1, "vga_scan_controller: CLK_DIV must exceed LOOKUP_LATENCY");
  end

  logic        pixStrobe;
  logic [9:0]  xNext;
  logic [9:0]  yNext;
  logic        activeNext;
  logic        hSyncNext;
  logic        vSyncNext;
  logic        activeD;
  logic        hSyncD;
  logic        vSyncD;
  logic [19:0] addrNext;
  color_t      pixColor;

  vga_sync_gen #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .CLK_DIV(CLK_DIV)
  ) uSyncGen (
    .clk       (clk),
    .resetn    (resetn),
    .pixStrobe (pixStrobe),
    .x         (x),
    .y         (y),
    .xNext     (xNext),
    .yNext     (yNext),
    .activeNext(activeNext),
    .hSyncNext (hSyncNext),
    .vSyncNext (vSyncNext),
    .frameStart(frameStart)
  );

  assign addrNext = activeNext ? (20'(yNext) * 20'(H_VISIBLE) + 20'(xNext)) : '0;
  assign pixColor = color_t'(colorData);
  assign vblank   = (y >= 10'(V_VISIBLE));

  // The delayed flags reset to the (0,0) values so the first captured pixel is
  // treated exactly like any other visible pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      imgAddress <= '0;
      activeD    <= 1'b1;
      hSyncD     <= 1'b1;
      vSyncD     <= 1'b1;
      hSync      <= 1'b1;
      vSync      <= 1'b1;
      VGA_R      <= '0;
      VGA_G      <= '0;
      VGA_B      <= '0;
    end else if (pixStrobe) begin
      imgAddress <= {12'd0, addrNext};
      activeD    <= activeNext;
      hSyncD     <= hSyncNext;
      vSyncD     <= vSyncNext;
      hSync      <= hSyncD;
      vSync      <= vSyncD;
      VGA_R      <= activeD ? pixColor.r : 4'd0;
      VGA_G      <= activeD ? pixColor.g : 4'd0;
      VGA_B      <= activeD ? pixColor.b : 4'd0;
    end
  end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench for vga_scan_controller: expectations keyed by reset epoch
// and clk count since release; a monitor pops and compares on falling edges.
module tb_vga_scan_controller;

  typedef enum {SIG_X, SIG_Y, SIG_HSYNC, SIG_VSYNC, SIG_RGB, SIG_ADDR, SIG_FRAME, SIG_VBLANK} sigSel_t;

  typedef struct {
    int          epoch;
    int          cyc;
    sigSel_t     sig;
    logic [31:0] expVal;
  } expect_t;

  expect_t scoreboard[$];
  int      total    = 0;
  int      bad      = 0;
  int      epoch    = 1;
  int      cycCount = 0;
  bit      running  = 0;

  logic        clk         = 1'b0;
  logic        resetn      = 1'b0;
  logic [11:0] colorData   = 12'd0;
  logic [11:0] lookupStage = 12'd0;
  logic [31:0] imgAddress;
  logic        hSync;
  logic        vSync;
  logic [3:0]  vgaR;
  logic [3:0]  vgaG;
  logic [3:0]  vgaB;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        vblank;
  logic        frameStart;

  // Vertical geometry shrunk to 8 lines (sync on lines 5-6) so whole frames fit.
  vga_scan_controller #(
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .colorData (colorData),
    .imgAddress(imgAddress),
    .hSync     (hSync),
    .vSync     (vSync),
    .VGA_R     (vgaR),
    .VGA_G     (vgaG),
    .VGA_B     (vgaB),
    .x         (x),
    .y         (y),
    .vblank    (vblank),
    .frameStart(frameStart)
  );

  always #5 clk = ~clk;

  // Image lookup stub: returns the address low bits two clk later.
  always @(posedge clk) begin
    lookupStage <= imgAddress[11:0];
    colorData   <= lookupStage;
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if (running) epoch = epoch + 1;
      running  = 0;
      cycCount = 0;
    end else begin
      running  = 1;
      cycCount = cycCount + 1;
    end
  end

  function automatic logic [31:0] sampleSig(sigSel_t sig);
    case (sig)
      SIG_X:      return {22'd0, x};
      SIG_Y:      return {22'd0, y};
      SIG_HSYNC:  return {31'd0, hSync};
      SIG_VSYNC:  return {31'd0, vSync};
      SIG_RGB:    return {20'd0, vgaR, vgaG, vgaB};
      SIG_ADDR:   return imgAddress;
      SIG_FRAME:  return {31'd0, frameStart};
      SIG_VBLANK: return {31'd0, vblank};
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic checkOutput(input expect_t e);
    logic [31:0] act;
    act   = sampleSig(e.sig);
    total = total + 1;
    if (act !== e.expVal) begin
      bad = bad + 1;
      $display("[TB] FAIL %s@%0d.%0d: got %0h expected %0h", e.sig.name(), e.epoch, e.cyc, act, e.expVal);
    end
  endtask

  always @(negedge clk) begin
    expect_t e;
    while (scoreboard.size() > 0 &&
           (scoreboard[0].epoch < epoch ||
            (scoreboard[0].epoch == epoch && scoreboard[0].cyc <= cycCount))) begin
      e = scoreboard.pop_front();
      if (e.epoch == epoch && e.cyc == cycCount) begin
        checkOutput(e);
      end else begin
        total = total + 1;
        bad   = bad + 1;
        $display("[TB] FAIL missed %s@%0d.%0d: not sampled, expected %0h", e.sig.name(), e.epoch, e.cyc, e.expVal);
      end
    end
  end

  task automatic expectAt(input int ep, input int cyc, input sigSel_t sig, input logic [31:0] val);
    expect_t e;
    e.epoch  = ep;
    e.cyc    = cyc;
    e.sig    = sig;
    e.expVal = val;
    scoreboard.push_back(e);
  endtask

  task automatic expectResetState(input int ep);
    expectAt(ep, 0, SIG_X, 0);
    expectAt(ep, 0, SIG_Y, 0);
    expectAt(ep, 0, SIG_HSYNC, 1);
    expectAt(ep, 0, SIG_VSYNC, 1);
    expectAt(ep, 0, SIG_RGB, 0);
    expectAt(ep, 0, SIG_ADDR, 0);
    expectAt(ep, 0, SIG_FRAME, 0);
  endtask

  // cyc n = state after the n-th rising edge following reset release; pixel p = n/4.
  task automatic applyStimulus();
    expectResetState(1);
    expectAt(1, 0, SIG_VBLANK, 0);
    expectAt(1, 3, SIG_X, 0);
    expectAt(1, 4, SIG_X, 1);
    expectAt(1, 4, SIG_ADDR, 1);
    expectAt(1, 2556, SIG_ADDR, 639);
    expectAt(1, 2560, SIG_ADDR, 0);
    expectAt(1, 2560, SIG_RGB, 12'h27F);
    expectAt(1, 2564, SIG_RGB, 0);
    expectAt(1, 2627, SIG_HSYNC, 1);
    expectAt(1, 2628, SIG_HSYNC, 0);
    expectAt(1, 3000, SIG_RGB, 0);
    expectAt(1, 3011, SIG_HSYNC, 0);
    expectAt(1, 3012, SIG_HSYNC, 1);
    expectAt(1, 3204, SIG_RGB, 12'h280);
    expectAt(1, 3204, SIG_ADDR, 641);
    expectAt(1, 5827, SIG_HSYNC, 1);
    expectAt(1, 5828, SIG_HSYNC, 0);
    expectAt(1, 6420, SIG_X, 5);
    expectAt(1, 6420, SIG_Y, 2);
    expectAt(1, 6420, SIG_ADDR, 1285);
    expectAt(1, 6420, SIG_RGB, 12'h504);
    expectAt(1, 12156, SIG_ADDR, 2559);
    expectAt(1, 12156, SIG_VBLANK, 0);
    expectAt(1, 12160, SIG_RGB, 12'h9FF);
    expectAt(1, 12800, SIG_Y, 4);
    expectAt(1, 12800, SIG_VBLANK, 1);
    expectAt(1, 12800, SIG_ADDR, 0);
    expectAt(1, 12804, SIG_RGB, 0);
    expectAt(1, 16000, SIG_VSYNC, 1);
    expectAt(1, 16004, SIG_VSYNC, 0);
    expectAt(1, 22400, SIG_VSYNC, 0);
    expectAt(1, 22400, SIG_VBLANK, 1);
    expectAt(1, 22404, SIG_VSYNC, 1);
    expectAt(1, 25599, SIG_FRAME, 0);
    expectAt(1, 25600, SIG_FRAME, 1);
    expectAt(1, 25600, SIG_X, 0);
    expectAt(1, 25600, SIG_Y, 0);
    expectAt(1, 25600, SIG_VBLANK, 0);
    expectAt(1, 25601, SIG_FRAME, 0);
    expectAt(1, 51199, SIG_FRAME, 0);
    expectAt(1, 51200, SIG_FRAME, 1);
    expectAt(1, 58800, SIG_X, 300);
    expectAt(1, 58800, SIG_Y, 2);
    expectAt(1, 58800, SIG_ADDR, 1580);
    expectAt(1, 58800, SIG_RGB, 12'h62B);
    expectResetState(2);
    expectAt(2, 4, SIG_X, 1);
    expectAt(2, 4, SIG_ADDR, 1);
    expectAt(2, 12, SIG_RGB, 12'h002);

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    repeat (58800) @(posedge clk);
    @(negedge clk);
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    expect_t e;
    applyStimulus();
    while (scoreboard.size() > 0) begin
      e     = scoreboard.pop_front();
      total = total + 1;
      bad   = bad + 1;
      $display("[TB] FAIL timeout %s@%0d.%0d: never reached, expected %0h", e.sig.name(), e.epoch, e.cyc, e.expVal);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
